// File: rtl/uart_cmd_asm.sv
//------------------------------------------------------------------------------
// Module   : uart_cmd_asm
// Brief    : Groups UART bytes into 24-bit {opcode, data_hi, data_lo} commands
//            with a sticky ready flag, an overrun flag and an inter-byte timeout.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_cmd_asm #(
  parameter int TMO_CYC = 52080,
  parameter int TMO_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  input  logic        clr_cmd_rdy,
  output logic        cmd_rdy,
  output logic [23:0] cmd,
  output logic        overrun,
  output logic        tmo_err
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_GET_MID = 2'd1;
  localparam logic [1:0] c_GET_LOW = 2'd2;

  localparam logic [TMO_W-1:0] c_TMO_LAST = TMO_W'(TMO_CYC - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [TMO_W-1:0] r_timer;
  logic [15:0]      r_asm;

  logic w_tmo_hit;
  logic w_ld_op;
  logic w_ld_mid;
  logic w_complete;
  logic w_tmo;
  logic w_timer_clr;

  assign w_tmo_hit = (r_timer == c_TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (rx_rdy) w_state_nxt = c_GET_MID;
      end
      c_GET_MID: begin
        if (rx_rdy)         w_state_nxt = c_GET_LOW;
        else if (w_tmo_hit) w_state_nxt = c_IDLE;
      end
      c_GET_LOW: begin
        if (rx_rdy || w_tmo_hit) w_state_nxt = c_IDLE;
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // A byte arriving on the last timer cycle takes priority over the timeout.
  always_comb begin
    w_ld_op     = 1'b0;
    w_ld_mid    = 1'b0;
    w_complete  = 1'b0;
    w_tmo       = 1'b0;
    w_timer_clr = 1'b1;
    case (r_state)
      c_IDLE: begin
        w_ld_op = rx_rdy;
      end
      c_GET_MID: begin
        w_ld_mid    = rx_rdy;
        w_tmo       = !rx_rdy && w_tmo_hit;
        w_timer_clr = rx_rdy || w_tmo_hit;
      end
      c_GET_LOW: begin
        w_complete  = rx_rdy;
        w_tmo       = !rx_rdy && w_tmo_hit;
        w_timer_clr = rx_rdy || w_tmo_hit;
      end
      default: begin
        w_timer_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (w_timer_clr) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_asm <= 16'h0;
    end else if (w_ld_op) begin
      r_asm[15:8] <= rx_data;
    end else if (w_ld_mid) begin
      r_asm[7:0] <= rx_data;
    end
  end

  // Acknowledge coincident with completion retires the old command, so no overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd     <= 24'h0;
      cmd_rdy <= 1'b0;
      overrun <= 1'b0;
    end else if (w_complete) begin
      cmd     <= {r_asm, rx_data};
      cmd_rdy <= 1'b1;
      overrun <= cmd_rdy && !clr_cmd_rdy;
    end else if (clr_cmd_rdy) begin
      cmd_rdy <= 1'b0;
      overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_err <= 1'b0;
    end else begin
      tmo_err <= w_tmo;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_asm.sv
//------------------------------------------------------------------------------
// Module   : tb_uart_cmd_asm
// Brief    : Directed self-checking bench for uart_cmd_asm (short timeout).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_cmd_asm;

  localparam int c_TMO = 40;

  logic        clk;
  logic        rst_n;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_cmd_rdy;
  logic        cmd_rdy;
  logic [23:0] cmd;
  logic        overrun;
  logic        tmo_err;

  int checks;
  int errors;
  int tmo_cnt;

  uart_cmd_asm #(.TMO_CYC(c_TMO), .TMO_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .clr_cmd_rdy (clr_cmd_rdy),
    .cmd_rdy     (cmd_rdy),
    .cmd         (cmd),
    .overrun     (overrun),
    .tmo_err     (tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (tmo_err) tmo_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_rdy  = 1'b1;
    rx_data = b;
    tick();
    rx_rdy  = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic ack();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h0; clr_cmd_rdy = 1'b0;
    idle(3);
    checks++;
    if ({cmd, cmd_rdy, overrun, tmo_err} !== 27'h0) begin
      errors++;
      $display("FAIL reset_outputs: got cmd=%h rdy=%b ovr=%b tmo=%b, expected all 0",
               cmd, cmd_rdy, overrun, tmo_err);
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_spaced_cmd();
    tmo_cnt = 0;
    send_byte(8'hA5); idle(c_TMO/2);
    send_byte(8'h12); idle(c_TMO/2);
    checks++;
    if (cmd_rdy !== 1'b0) begin
      errors++; $display("FAIL t1_rdy_early: got %b expected 0", cmd_rdy);
    end
    send_byte(8'h34);
    checks++;
    if (cmd !== 24'hA51234) begin
      errors++; $display("FAIL t1_cmd: got %h expected a51234", cmd);
    end
    checks++;
    if (cmd_rdy !== 1'b1 || overrun !== 1'b0) begin
      errors++; $display("FAIL t1_flags: got rdy=%b ovr=%b expected 1/0", cmd_rdy, overrun);
    end
    checks++;
    if (tmo_cnt !== 0) begin
      errors++; $display("FAIL t1_no_tmo: got %0d pulses expected 0", tmo_cnt);
    end
  endtask

  task automatic test_timeout();
    ack();
    checks++;
    if (cmd_rdy !== 1'b0) begin
      errors++; $display("FAIL t2_ack: got rdy=%b expected 0", cmd_rdy);
    end
    tmo_cnt = 0;
    send_byte(8'h01);
    send_byte(8'h02);
    idle(c_TMO - 1);
    checks++;
    if (tmo_err !== 1'b0) begin
      errors++; $display("FAIL t2_tmo_early: got %b expected 0", tmo_err);
    end
    tick();
    checks++;
    if (tmo_err !== 1'b1) begin
      errors++; $display("FAIL t2_tmo_pulse: got %b expected 1", tmo_err);
    end
    tick();
    checks++;
    if (tmo_err !== 1'b0 || tmo_cnt !== 1) begin
      errors++; $display("FAIL t2_tmo_once: got tmo=%b cnt=%0d expected 0/1", tmo_err, tmo_cnt);
    end
    checks++;
    if (cmd !== 24'hA51234 || cmd_rdy !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL t2_outputs_held: got cmd=%h rdy=%b ovr=%b expected a51234/0/0",
                         cmd, cmd_rdy, overrun);
    end
    idle(5);
    send_byte(8'h03); send_byte(8'h04); send_byte(8'h05);
    checks++;
    if (cmd !== 24'h030405 || cmd_rdy !== 1'b1) begin
      errors++; $display("FAIL t2_after_tmo: got cmd=%h rdy=%b expected 030405/1", cmd, cmd_rdy);
    end
  endtask

  task automatic test_overrun();
    ack();
    send_byte(8'h11); send_byte(8'h11); send_byte(8'h11);
    checks++;
    if (cmd !== 24'h111111 || cmd_rdy !== 1'b1 || overrun !== 1'b0) begin
      errors++; $display("FAIL t3_first: got cmd=%h rdy=%b ovr=%b expected 111111/1/0",
                         cmd, cmd_rdy, overrun);
    end
    send_byte(8'h22); idle(3); send_byte(8'h22);
    checks++;
    if (cmd !== 24'h111111) begin
      errors++; $display("FAIL t3_cmd_stable: got %h expected 111111", cmd);
    end
    send_byte(8'h22);
    checks++;
    if (cmd !== 24'h222222 || cmd_rdy !== 1'b1 || overrun !== 1'b1) begin
      errors++; $display("FAIL t3_overrun: got cmd=%h rdy=%b ovr=%b expected 222222/1/1",
                         cmd, cmd_rdy, overrun);
    end
    ack();
    checks++;
    if (cmd_rdy !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL t3_clear: got rdy=%b ovr=%b expected 0/0", cmd_rdy, overrun);
    end
  endtask

  task automatic test_ack_coincident();
    send_byte(8'h99); send_byte(8'h88); send_byte(8'h77);
    send_byte(8'h0A); send_byte(8'h0B);
    clr_cmd_rdy = 1'b1;
    send_byte(8'h0C);
    clr_cmd_rdy = 1'b0;
    checks++;
    if (cmd !== 24'h0A0B0C || cmd_rdy !== 1'b1 || overrun !== 1'b0) begin
      errors++; $display("FAIL t4_ack_same_cycle: got cmd=%h rdy=%b ovr=%b expected 0a0b0c/1/0",
                         cmd, cmd_rdy, overrun);
    end
  endtask

  task automatic test_tmo_boundary_and_reset();
    tmo_cnt = 0;
    send_byte(8'h5A);
    idle(c_TMO - 1);
    send_byte(8'h6B);
    idle(2);
    send_byte(8'h7C);
    checks++;
    if (tmo_cnt !== 0) begin
      errors++; $display("FAIL t5_byte_wins: got %0d tmo pulses expected 0", tmo_cnt);
    end
    checks++;
    if (cmd !== 24'h5A6B7C || overrun !== 1'b1) begin
      errors++; $display("FAIL t5_boundary_cmd: got cmd=%h ovr=%b expected 5a6b7c/1", cmd, overrun);
    end
    send_byte(8'hD1); send_byte(8'hD2);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd, cmd_rdy, overrun, tmo_err} !== 27'h0) begin
      errors++; $display("FAIL t5_async_reset: got cmd=%h rdy=%b ovr=%b tmo=%b expected all 0",
                         cmd, cmd_rdy, overrun, tmo_err);
    end
    tick();
    rst_n = 1'b1;
    idle(2);
    send_byte(8'hE1); send_byte(8'hE2);
    checks++;
    if (cmd_rdy !== 1'b0) begin
      errors++; $display("FAIL t5_partial_dropped: got rdy=%b expected 0", cmd_rdy);
    end
    send_byte(8'hE3);
    checks++;
    if (cmd !== 24'hE1E2E3 || cmd_rdy !== 1'b1 || overrun !== 1'b0 || tmo_cnt !== 0) begin
      errors++; $display("FAIL t5_after_reset: got cmd=%h rdy=%b ovr=%b tmo=%0d expected e1e2e3/1/0/0",
                         cmd, cmd_rdy, overrun, tmo_cnt);
    end
  endtask

  task automatic test_back_to_back();
    ack();
    send_byte(8'hDE); send_byte(8'hAD);
    checks++;
    if (cmd_rdy !== 1'b0 || cmd !== 24'hE1E2E3) begin
      errors++; $display("FAIL t6_pending: got rdy=%b cmd=%h expected 0/e1e2e3", cmd_rdy, cmd);
    end
    send_byte(8'hBE);
    checks++;
    if (cmd !== 24'hDEADBE || cmd_rdy !== 1'b1 || overrun !== 1'b0) begin
      errors++; $display("FAIL t6_b2b: got cmd=%h rdy=%b ovr=%b expected deadbe/1/0",
                         cmd, cmd_rdy, overrun);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    tmo_cnt = 0;
    test_reset();
    test_spaced_cmd();
    test_timeout();
    test_overrun();
    test_ack_coincident();
    test_tmo_boundary_and_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
